dk_sound_mixer: RTL

//  Final mix stage downstream of dk_walk and its sibling discrete voices (jump, stomp, DAC music).

---
 rtl/dk_audio_pkg.sv | 40 ++++
 rtl/dk_dc_blocker.sv | 52 +++++
 rtl/dk_sound_mixer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dk_audio_pkg.sv
// Shared audio types, constants and the 16-bit clamp helper for the dk sound path.
package dk_audio_pkg;

  localparam int SIGNAL_WIDTH = 16;
  localparam int GAIN_WIDTH   = 8;
  localparam int UNITY_GAIN   = 128;

  typedef logic signed [SIGNAL_WIDTH-1:0] sample_t;
  typedef logic        [GAIN_WIDTH-1:0]   gain_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SCALE,
    ST_DCB,
    ST_OUTPUT
  } mix_state_t;

  typedef struct packed {
    sample_t value;
    logic    clipped;
  } sat_t;

  // Clamp a wide signed value into the 16-bit sample range, flagging when it had to clamp.
  function automatic sat_t sat16(input logic signed [31:0] x);
    sat_t r;
    if (x > 32'sd32767) begin
      r.value   = 16'sh7fff;
      r.clipped = 1'b1;
    end else if (x < -32'sd32768) begin
      r.value   = 16'sh8000;
      r.clipped = 1'b1;
    end else begin
      r.value   = x[15:0];
      r.clipped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/dk_dc_blocker.sv
// One-pole high-pass (DC blocker) with an enable strobe; updates its history once per strobe.
module dk_dc_blocker
  import dk_audio_pkg::*;
#(
  parameter int DC_SHIFT = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  sample_t x,
  output sample_t y,
  output logic    clip
);

  sample_t            x_prev;
  logic signed [17:0] y_prev;
  logic signed [19:0] y_full;
  logic signed [17:0] y18;
  logic               clip18;
  sat_t               y_sat;

  // The recursive state is kept at 18 bits so the pole has headroom beyond the output range.
  always_comb begin
    y_full = 20'(x) - 20'(x_prev) + 20'(y_prev) - 20'(y_prev >>> DC_SHIFT);
    clip18 = 1'b0;
    if (y_full > 20'sd131071) begin
      y18    = 18'sh1ffff;
      clip18 = 1'b1;
    end else if (y_full < -20'sd131072) begin
      y18    = 18'sh20000;
      clip18 = 1'b1;
    end else begin
      y18 = y_full[17:0];
    end
    y_sat = sat16(32'(y18));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_prev <= '0;
      y_prev <= '0;
      y      <= '0;
      clip   <= 1'b0;
    end else if (en) begin
      x_prev <= x;
      y_prev <= y18;
      y      <= y_sat.value;
      clip   <= y_sat.clipped | clip18;
    end
  end

endmodule

// File: rtl/dk_sound_mixer.sv
// Final voice mix: snapshot per audio tick, shared MAC over NUM_CH cycles, scale and saturate.
// Optional DC blocker stage enabled by defining DK_MIXER_DC_BLOCK_EN.
module dk_sound_mixer
  import dk_audio_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int GAIN_FRAC = 7,
  parameter int DC_SHIFT  = 8
) (
  input  logic                                 clk,
  input  logic                                 I_RST,
  input  logic                                 audio_clk_en,
  input  logic [NUM_CH-1:0][SIGNAL_WIDTH-1:0]  ch_in,
  input  logic [NUM_CH-1:0][GAIN_WIDTH-1:0]    ch_gain,
  output sample_t                              out,
  output logic                                 out_valid,
  output logic                                 clip,
  output logic                                 overrun
);

  localparam int ACC_W = 24 + $clog2(NUM_CH);
  localparam int IDX_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 8 || DC_SHIFT < 1 || DC_SHIFT > 16) begin : g_param_check
    $error("dk_sound_mixer: parameter out of range");
  end

  mix_state_t                state;
  sample_t                   snap_ch   [NUM_CH];
  gain_t                     snap_gain [NUM_CH];
  logic signed [ACC_W-1:0]   acc;
  logic        [IDX_W-1:0]   idx;
  sample_t                   result;
  logic                      clip_pend;

  logic signed [24:0]        prod;
  logic signed [ACC_W-1:0]   scaled;
  sat_t                      scale_sat;
  sample_t                   final_val;
  logic                      final_clip;

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign prod      = snap_ch[idx] * $signed({1'b0, snap_gain[idx]});
  assign scaled    = acc >>> GAIN_FRAC;
  assign scale_sat = sat16(32'(scaled));

`ifdef DK_MIXER_DC_BLOCK_EN
  localparam mix_state_t POST_SCALE = ST_DCB;
  sample_t dcb_y;
  logic    dcb_clip;

  dk_dc_blocker #(
    .DC_SHIFT(DC_SHIFT)
  ) u_dc_blocker (
    .clk  (clk),
    .rst  (I_RST),
    .en   (state == ST_DCB),
    .x    (result),
    .y    (dcb_y),
    .clip (dcb_clip)
  );

  assign final_val  = dcb_y;
  assign final_clip = clip_pend | dcb_clip;
`else
  localparam mix_state_t POST_SCALE = ST_OUTPUT;

  assign final_val  = result;
  assign final_clip = clip_pend;
`endif

  always_ff @(posedge clk) begin
    if (I_RST) begin
      state     <= ST_IDLE;
      acc       <= '0;
      idx       <= '0;
      result    <= '0;
      clip_pend <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_ch[i]   <= '0;
        snap_gain[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      clip      <= 1'b0;
      if (audio_clk_en && state != ST_IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (audio_clk_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
              snap_ch[i]   <= ch_in[i];
              snap_gain[i] <= ch_gain[i];
            end
            acc   <= '0;
            idx   <= '0;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc <= acc + ACC_W'(prod);
          if (idx == IDX_W'(NUM_CH - 1)) begin
            state <= ST_SCALE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_SCALE: begin
          result    <= scale_sat.value;
          clip_pend <= scale_sat.clipped;
          state     <= POST_SCALE;
        end
`ifdef DK_MIXER_DC_BLOCK_EN
        ST_DCB: begin
          state <= ST_OUTPUT;
        end
`endif
        ST_OUTPUT: begin
          out       <= final_val;
          out_valid <= 1'b1;
          clip      <= final_clip;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
